ped_request: RTL

PED_REQUEST -- requirements
Module: ped_request

---
 rtl/ped_request_pkg.sv | 15 +
 rtl/ped_debounce.sv | 55 +++++
 rtl/ped_request.sv | 90 +++++++++
 3 files changed

// File: rtl/ped_request_pkg.sv
// Pedestrian request: FSM state encoding and phase threshold.
// Shared by ped_request and ped_debounce.
package ped_request_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        ASSERT   = 2'd2,
        COOLDOWN = 2'd3
    } ped_state_t;

    localparam logic [7:0] PASS_THRESH = 8'd10;
    localparam int         CNT_W       = 16;

endpackage

// File: rtl/ped_debounce.sv
// Button synchronizer with optional stability filter.
// Filter present only when PED_REQUEST_DEBOUNCE_EN is defined.
module ped_debounce
    import ped_request_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

`ifdef PED_REQUEST_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Any cycle that agrees with the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    // Filter omitted: the synchronized value is the level.
    if (DEBOUNCE_CYCLES > 0) begin : g_sync
        assign level = sync_q[1];
    end else begin : g_sync_min
        assign level = sync_q[1];
    end
`endif

endmodule

// File: rtl/ped_request.sv
// Pedestrian request FSM: press edge -> green shortening -> cooldown.
// Define PED_REQUEST_DEBOUNCE_EN to compile in the button filter.
module ped_request
    import ped_request_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned COOLDOWN_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       green,
    input  logic [7:0] clock_in,
    output logic       pass_request,
    output logic       req_pending,
    output logic       served
);

    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    logic             level;
    logic             level_q;
    logic             press;
    logic             long_phase;
    ped_state_t       state_q;
    ped_state_t       state_d;
    logic [CNT_W-1:0] cd_q;
    logic [CNT_W-1:0] cd_d;
    logic             pass_d;
    logic             pend_d;
    logic             served_d;
    logic             enter_cd;

    ped_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .level  (level)
    );

    assign press      = level & ~level_q;
    assign long_phase = clock_in > PASS_THRESH;

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        unique case (state_q)
            IDLE: begin
                if (press) state_d = ARMED;
            end
            ARMED: begin
                if (green) state_d = long_phase ? ASSERT : COOLDOWN;
            end
            ASSERT: begin
                if (!green || !long_phase) state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (cd_q == '0) state_d = IDLE;
                else            cd_d    = cd_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        enter_cd = (state_d == COOLDOWN) && (state_q != COOLDOWN);
        if (enter_cd) cd_d = CD_LOAD;
        pass_d   = state_d == ASSERT;
        pend_d   = (state_d == ARMED) || (state_d == ASSERT);
        served_d = enter_cd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q      <= 1'b0;
            state_q      <= IDLE;
            cd_q         <= '0;
            pass_request <= 1'b0;
            req_pending  <= 1'b0;
            served       <= 1'b0;
        end else begin
            level_q      <= level;
            state_q      <= state_d;
            cd_q         <= cd_d;
            pass_request <= pass_d;
            req_pending  <= pend_d;
            served       <= served_d;
        end
    end

endmodule
